// File: rtl/alu_packet_responder.sv
// Packet engine for the UART ALU: parses host packets, runs ADD/MUL/DIV/ECHO, streams results.
// Optional divider is built only when ALU_DIV_EN is defined.
module alu_packet_responder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OPND_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned NumBytes = OPND_WIDTH / DATA_WIDTH;
  localparam int unsigned IdxW     = $clog2(NumBytes);
  localparam int unsigned Msb      = OPND_WIDTH - 1;

  localparam logic [7:0] OpAdd  = 8'h01;
  localparam logic [7:0] OpMul  = 8'h02;
  localparam logic [7:0] OpEcho = 8'hEC;
`ifdef ALU_DIV_EN
  localparam logic [7:0] OpDiv  = 8'h03;
`endif

  typedef enum logic [3:0] {
    StIdle, StRsvd, StLenLo, StLenHi, StDispatch, StOpnd, StCompute,
    StResp, StEchoRx, StEchoTx, StDrain
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [OPND_WIDTH-1:0]  opnd_q, opnd_d;
  logic [OPND_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  echo_q, echo_d;

`ifdef ALU_DIV_EN
  logic                   first_q, first_d;
  logic [5:0]             div_step_q, div_step_d;
  logic                   div_neg_q, div_neg_d;
  logic [OPND_WIDTH-1:0]  div_quo_q, div_quo_d;
  logic [OPND_WIDTH-1:0]  div_dsr_q, div_dsr_d;
  logic [OPND_WIDTH-1:0]  div_rem_q, div_rem_d;
  logic [OPND_WIDTH:0]    div_shift;
`endif

  logic                   s_rdy, m_vld, err_pulse, done;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   is_arith, is_echo, malformed;
  logic [15:0]            payload_len;

`ifdef ALU_DIV_EN
  assign is_arith = (opcode_q == OpAdd) || (opcode_q == OpMul) || (opcode_q == OpDiv);
`else
  assign is_arith = (opcode_q == OpAdd) || (opcode_q == OpMul);
`endif
  assign is_echo     = (opcode_q == OpEcho);
  assign payload_len = (len_q < 16'd4) ? 16'd0 : len_q - 16'd4;
  assign malformed   = (len_q < 16'd4) || !(is_arith || is_echo) ||
                       (is_arith && ((payload_len == 16'd0) || (payload_len[IdxW-1:0] != '0)));

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    echo_d    = echo_q;
    s_rdy     = 1'b0;
    m_vld     = 1'b0;
    m_data    = '0;
    err_pulse = 1'b0;
    done      = 1'b0;
`ifdef ALU_DIV_EN
    first_d    = first_q;
    div_step_d = div_step_q;
    div_neg_d  = div_neg_q;
    div_quo_d  = div_quo_q;
    div_dsr_d  = div_dsr_q;
    div_rem_d  = div_rem_q;
    div_shift  = '0;
`endif

    unique case (state_q)
      StIdle: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          opcode_d = s_axis_tdata;
          state_d  = StRsvd;
        end
      end
      StRsvd: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) state_d = StLenLo;
      end
      StLenLo: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          len_d[7:0] = s_axis_tdata;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          len_d[15:8] = s_axis_tdata;
          state_d     = StDispatch;
        end
      end
      StDispatch: begin
        cnt_d = payload_len;
        idx_d = '0;
`ifdef ALU_DIV_EN
        first_d    = 1'b1;
        div_step_d = '0;
`endif
        if (malformed) begin
          err_pulse = 1'b1;
          state_d   = (payload_len == 16'd0) ? StIdle : StDrain;
        end else if (is_echo) begin
          state_d = (payload_len == 16'd0) ? StIdle : StEchoRx;
        end else begin
          acc_d   = (opcode_q == OpMul) ? OPND_WIDTH'(1) : '0;
          state_d = StOpnd;
        end
      end
      StOpnd: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          opnd_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
          cnt_d = cnt_q - 16'd1;
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxW'(NumBytes - 1)) state_d = StCompute;
        end
      end
      StCompute: begin
        case (opcode_q)
          OpAdd: begin
            acc_d = acc_q + opnd_q;
            done  = 1'b1;
          end
          OpMul: begin
            acc_d = acc_q * opnd_q;
            done  = 1'b1;
          end
`ifdef ALU_DIV_EN
          OpDiv: begin
            // Step 0 takes magnitudes, steps 1..32 are restoring iterations, step 33 fixes sign.
            if (first_q) begin
              acc_d   = opnd_q;
              first_d = 1'b0;
              done    = 1'b1;
            end else if (opnd_q == '0) begin
              acc_d = '1;
              done  = 1'b1;
            end else if (div_step_q == 6'd0) begin
              div_neg_d  = acc_q[Msb] ^ opnd_q[Msb];
              div_quo_d  = acc_q[Msb] ? -acc_q : acc_q;
              div_dsr_d  = opnd_q[Msb] ? -opnd_q : opnd_q;
              div_rem_d  = '0;
              div_step_d = div_step_q + 6'd1;
            end else if (div_step_q <= 6'd32) begin
              div_shift = {div_rem_q, div_quo_q[Msb]};
              if (div_shift >= {1'b0, div_dsr_q}) begin
                div_rem_d = OPND_WIDTH'(div_shift - {1'b0, div_dsr_q});
                div_quo_d = {div_quo_q[Msb-1:0], 1'b1};
              end else begin
                div_rem_d = div_shift[Msb:0];
                div_quo_d = {div_quo_q[Msb-1:0], 1'b0};
              end
              div_step_d = div_step_q + 6'd1;
            end else begin
              acc_d = div_neg_q ? -div_quo_q : div_quo_q;
              done  = 1'b1;
            end
          end
`endif
          default: done = 1'b1;
        endcase
        if (done) begin
          idx_d   = '0;
          state_d = (cnt_q == 16'd0) ? StResp : StOpnd;
`ifdef ALU_DIV_EN
          div_step_d = '0;
`endif
        end
      end
      StResp: begin
        m_vld  = 1'b1;
        m_data = acc_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
        if (m_axis_tready) begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxW'(NumBytes - 1)) state_d = StIdle;
        end
      end
      StEchoRx: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid) begin
          echo_d  = s_axis_tdata;
          cnt_d   = cnt_q - 16'd1;
          state_d = StEchoTx;
        end
      end
      StEchoTx: begin
        m_vld  = 1'b1;
        m_data = echo_q;
        if (m_axis_tready) state_d = (cnt_q == 16'd0) ? StIdle : StEchoRx;
      end
      StDrain: begin
        s_rdy = 1'b1;
        if (cnt_q == 16'd0) begin
          state_d = StIdle;
        end else if (s_axis_tvalid) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs read as reset values for the whole time rst is high, not only after the edge.
  assign s_axis_tready = s_rdy & ~rst;
  assign m_axis_tvalid = m_vld & ~rst;
  assign m_axis_tdata  = rst ? '0 : m_data;
  assign error         = err_pulse & ~rst;
  assign busy          = (state_q != StIdle) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      echo_q   <= '0;
`ifdef ALU_DIV_EN
      first_q    <= 1'b0;
      div_step_q <= '0;
      div_neg_q  <= 1'b0;
      div_quo_q  <= '0;
      div_dsr_q  <= '0;
      div_rem_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      echo_q   <= echo_d;
`ifdef ALU_DIV_EN
      first_q    <= first_d;
      div_step_q <= div_step_d;
      div_neg_q  <= div_neg_d;
      div_quo_q  <= div_quo_d;
      div_dsr_q  <= div_dsr_d;
      div_rem_q  <= div_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_packet_responder.sv
// Bench for alu_packet_responder: directed packets plus random traffic against a packet-level model.
module tb_alu_packet_responder;

  typedef bit [7:0]  bq_t[$];
  typedef bit [31:0] wq_t[$];

  logic       clk;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy;
  logic       error;

  int  checks = 0;
  int  errors = 0;
  int  err_cnt = 0;
  int  stall_viol = 0;
  int  rdy_mode = 0;
  int  gap_max = 0;
  bq_t out_q;

  alu_packet_responder #(.DATA_WIDTH(8), .OPND_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .error        (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Output-side ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Collects output handshakes, error pulses and stalled bytes that change.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (error === 1'b1) err_cnt++;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) out_q.push_back(m_axis_tdata);
      if (rst !== 1'b1 && prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data))
        stall_viol++;
      prev_stall = (rst !== 1'b1) && (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
      prev_data  = m_axis_tdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Packet-level reference: result bytes and whether an error pulse is due.
  function automatic void model(input bq_t pkt, output bq_t resp, output bit err);
    int         len, pay, sa, sb;
    bit [7:0]   op;
    bit         arith, div_en;
    bit [31:0]  w, acc;
    resp.delete();
    err = 1'b0;
    op  = pkt[0];
    len = {pkt[3], pkt[2]};
    pay = len - 4;
`ifdef ALU_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    arith = (op == 8'h01) || (op == 8'h02) || (op == 8'h03 && div_en);
    if (len < 4 || !(arith || op == 8'hEC) || (arith && (pay == 0 || pay % 4 != 0))) begin
      err = 1'b1;
      return;
    end
    if (op == 8'hEC) begin
      for (int i = 0; i < pay; i++) resp.push_back(pkt[4+i]);
      return;
    end
    acc = (op == 8'h02) ? 32'd1 : 32'd0;
    for (int k = 0; k < pay / 4; k++) begin
      w = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
      if (op == 8'h01) acc = acc + w;
      else if (op == 8'h02) acc = acc * w;
      else if (k == 0) acc = w;
      else if (w == 32'd0) acc = 32'hFFFF_FFFF;
      else if (!(acc == 32'h8000_0000 && w == 32'hFFFF_FFFF)) begin
        sa  = acc;
        sb  = w;
        sa  = sa / sb;
        acc = sa;
      end
    end
    for (int b = 0; b < 4; b++) resp.push_back(acc[8*b +: 8]);
  endfunction

  task automatic build_arith(input bit [7:0] op, input wq_t w, output bq_t pkt);
    int len;
    len = 4 + 4 * w.size();
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'h00);
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    foreach (w[i]) for (int b = 0; b < 4; b++) pkt.push_back(w[i][8*b +: 8]);
  endtask

  // Called and returns at posedge+1.
  task automatic send_byte(input bit [7:0] b);
    int t;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (s_axis_tready !== 1'b1 && t < 2000);
    check("send tready", {31'b0, s_axis_tready}, 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic run_packet(input string tag, input bq_t pkt, output logic [31:0] word);
    bq_t exp_q;
    bit  exp_err;
    int  base, t;
    model(pkt, exp_q, exp_err);
    out_q.delete();
    base = err_cnt;
    foreach (pkt[i]) send_byte(pkt[i]);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy === 1'b1 && t < 5000);
    check({tag, " idle"}, {31'b0, busy}, 32'd0);
    check({tag, " nbytes"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), out_q[i], exp_q[i]);
    check({tag, " error"}, err_cnt - base, {31'b0, exp_err});
    word = '0;
    for (int i = 0; i < 4 && i < out_q.size(); i++) word[8*i +: 8] = out_q[i];
    @(posedge clk);
    #1;
  endtask

  initial begin
    bq_t         pkt;
    wq_t         w;
    logic [31:0] word;
    int          sel, n;

    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst s_tready", {31'b0, s_axis_tready}, 32'd0);
    check("rst m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst m_tdata", {24'b0, m_axis_tdata}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst error", {31'b0, error}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle s_tready", {31'b0, s_axis_tready}, 32'd1);
    @(posedge clk);
    #1;

    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    run_packet("echo4", pkt, word);
    check("echo4 word", word, 32'h1122_3344);

    build_arith(8'h01, '{32'h1, 32'h2, 32'hFFFF_FFFF}, pkt);
    run_packet("add3", pkt, word);
    check("add3 word", word, 32'h0000_0002);

    rdy_mode = 1;
    build_arith(8'h02, '{32'h0001_0000, 32'h0001_0003}, pkt);
    run_packet("mul_stall", pkt, word);
    check("mul_stall word", word, 32'h0003_0000);
    check("mul_stall hold", stall_viol, 32'd0);
    rdy_mode = 0;

    build_arith(8'h03, '{32'hFFFF_FFF9, 32'h2}, pkt);
    run_packet("div_neg", pkt, word);
`ifdef ALU_DIV_EN
    check("div_neg word", word, 32'hFFFF_FFFD);
`endif
    build_arith(8'h03, '{32'd100, 32'd0}, pkt);
    run_packet("div_zero", pkt, word);
`ifdef ALU_DIV_EN
    check("div_zero word", word, 32'hFFFF_FFFF);
    build_arith(8'h03, '{32'h8000_0000, 32'hFFFF_FFFF}, pkt);
    run_packet("div_ovf", pkt, word);
    check("div_ovf word", word, 32'h8000_0000);
`endif

    pkt = '{8'h01, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    run_packet("malformed", pkt, word);
    build_arith(8'h01, '{32'd5, 32'd6}, pkt);
    run_packet("add_after_bad", pkt, word);
    check("add_after_bad word", word, 32'h0000_000B);

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02};
    run_packet("unknown_op", pkt, word);
    pkt = '{8'h01, 8'h00, 8'h02, 8'h00};
    run_packet("len_short", pkt, word);
    pkt = '{8'h02, 8'h00, 8'h04, 8'h00};
    run_packet("arith_empty", pkt, word);
    pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
    run_packet("echo_empty", pkt, word);

    // Abandon an ADD after its second operand byte.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0C);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("midrst s_tready", {31'b0, s_axis_tready}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    build_arith(8'h01, '{32'd5, 32'd6}, pkt);
    run_packet("add_after_rst", pkt, word);
    check("add_after_rst word", word, 32'h0000_000B);

    for (int r = 0; r < 40; r++) begin
      rdy_mode = $urandom_range(0, 2);
      gap_max  = $urandom_range(0, 2);
      sel      = $urandom_range(0, 3);
      n        = $urandom_range(1, 4);
      w.delete();
      if (sel == 3) begin
        n = $urandom_range(0, 6);
        pkt.delete();
        pkt.push_back(8'hEC);
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(n + 4));
        pkt.push_back(8'h00);
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      end else begin
        for (int i = 0; i < n; i++) begin
          if (sel == 2 && i > 0 && $urandom_range(0, 4) == 0) w.push_back(32'd0);
          else if (sel == 2 && i > 0) w.push_back(32'($urandom_range(0, 40)) - 32'd20);
          else w.push_back($urandom);
        end
        build_arith(8'(sel + 1), w, pkt);
      end
      run_packet($sformatf("rand%0d", r), pkt, word);
    end
    rdy_mode = 0;
    check("stall hold total", stall_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_packet_responder.md
# alu_packet_responder

Device-side packet engine for the UART ALU. Sits between `uart_rx` (AXI-Stream master) and `uart_tx` (AXI-Stream slave) inside the top level. It parses host packets, runs add, multiply, divide or echo, and streams the 32-bit result back byte-wise. It is the responder for the host-side packet initiator used by the system bench.

## Interface
Parameters:
- `DATA_WIDTH`, 8: stream byte width; only 8 supported.
- `OPND_WIDTH`, 32: operand and result width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `s_axis_tdata`  in  8  byte from `uart_rx`.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  byte accepted when high with valid.
- `m_axis_tdata`  out  8  byte to `uart_tx`.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tready`  in  1  `uart_tx` ready.
- `busy`  out  1  high outside IDLE.
- `error`  out  1  one-cycle pulse on a malformed or unknown packet.

## Operation
- Packet byte order: opcode, reserved (ignored), LEN[7:0], LEN[15:8], payload. LEN counts the total bytes, including the 4-byte header.
- Operands and results are little-endian: LSB first.
- Opcodes:
  - 0x01 ADD: wrap-around sum, acc init 0.
  - 0x02 MUL: low 32 bits of the product, acc init 1.
  - 0x03 DIV: signed, truncating toward zero. The first operand loads acc; each later operand divides acc, left to right. A zero divisor sets acc to 0xFFFFFFFF and skips that step. 0x80000000 / -1 gives 0x80000000.
  - 0xEC ECHO: LEN-4 payload bytes are returned unchanged, in order; no result word.
- FSM states: IDLE (opcode) -> RSVD -> LEN_LO -> LEN_HI -> DISPATCH -> {OPND, ECHO_RX, DRAIN}.
  - OPND collects 4 bytes, then goes to COMPUTE, then back to OPND, or to RESP after the last operand.
  - ECHO_RX <-> ECHO_TX alternate per byte.
  - RESP, DRAIN and ECHO end in IDLE.
- Malformed packet (arithmetic with LEN-4 zero or not a multiple of 4; LEN < 4; unknown opcode):
  - `error` pulses in DISPATCH.
  - Remaining bytes (max(LEN-4, 0)) are drained with no response.
- Payload counter is 16 bits. It never wraps, because LEN is at most 0xFFFF.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `busy`=0, `error`=0. FSM returns to IDLE and acc clears.
- `s_axis_tready` is high only in IDLE, RSVD, LEN_LO, LEN_HI, OPND, ECHO_RX and DRAIN. It is low in DISPATCH, COMPUTE, ECHO_TX and RESP. One byte is accepted per cycle at most.
- DISPATCH takes 1 cycle.
- COMPUTE duration:
  - ADD and MUL: 1 cycle.
  - DIV: 34 cycles (sign fix, 32 restoring iterations, sign restore). A zero divisor takes 1 cycle.
- Result latency: the first result byte is valid on the cycle after COMPUTE ends for the last operand.
- RESP presents 4 bytes. Each byte is held stable while `m_axis_tvalid`=1 and `m_axis_tready`=0, and advances the cycle after the handshake. After the 4th handshake the FSM goes to IDLE.
- Echo: the byte is accepted in ECHO_RX, then `m_axis_tvalid` rises the next cycle. After the handshake, `s_axis_tready` rises the next cycle.
- Reset mid-packet abandons the packet and any partially sent response. The next cycle is IDLE.
- Simultaneous `s_axis_tvalid` and an output stall: input is simply not accepted (tready low). No byte is lost.

## Configuration
- `ALU_DIV_EN`:
  - Defined: the divider is built and opcode 0x03 works as above.
  - Undefined: no divider logic. Opcode 0x03 is an unknown opcode: `error` pulse, payload drained, no response.

## Test plan
- Echo: EC 00 08 00 44 33 22 11 -> m_axis emits 44 33 22 11; `error` stays 0.
- ADD three operands: 0x00000001, 0x00000002, 0xFFFFFFFF (LEN 16) -> 02 00 00 00.
- MUL: 0x00010000 × 0x00010003 (LEN 12) -> 00 00 03 00; with `m_axis_tready` toggled every other cycle, the same bytes come out, each held stable until accepted.
- DIV (macro defined):
  - -7 / 2 -> FD FF FF FF.
  - 100 / 0 -> FF FF FF FF.
  - Without the macro, opcode 03 -> `error` pulse, 8 bytes drained, no output.
- Malformed: 01 00 06 00 AA BB -> `error` pulse, 2 bytes drained, no output. The following ADD 5+6 returns 0B 00 00 00.
- Reset asserted after the 2nd operand byte of an ADD -> outputs at reset values. The next full packet computes correctly.
